// File: rtl/perf_overflow_irq.sv
// Overflow tracker for the HPM counters: sticky per-counter OF bits, scountovf view,
// and the LCOFIP pending bit with its level interrupt request.
module perf_overflow_irq #(
  parameter int unsigned NumCounters = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      debug_mode_i,
  input  logic [NumCounters*64-1:0] cnt_i,
  input  logic [NumCounters-1:0]    cnt_inc_i,
  input  logic [NumCounters-1:0]    cnt_we_i,
  input  logic                      of_we_i,
  input  logic [NumCounters-1:0]    of_wsel_i,
  input  logic                      of_wdata_i,
  input  logic                      lcofip_we_i,
  input  logic                      lcofip_wdata_i,
  input  logic                      lcofie_i,
  output logic [NumCounters-1:0]    of_o,
  output logic [31:0]               scountovf_o,
  output logic                      lcofip_o,
  output logic                      irq_o
);

  logic [NumCounters-1:0] wrap;
  logic [NumCounters-1:0] rise;
  logic [NumCounters-1:0] of_d, of_q;
  logic                   lcofip_d, lcofip_q;

  // A counter wraps when it increments from all-ones; a same-cycle software write
  // replaces the increment, and debug mode masks detection entirely.
  always_comb begin
    wrap = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      wrap[k] = cnt_inc_i[k] & (cnt_i[k*64 +: 64] == {64{1'b1}}) & ~cnt_we_i[k] & ~debug_mode_i;
    end
  end

  assign rise = wrap & ~of_q;

  // Hardware set takes priority over a same-cycle software write.
  always_comb begin
    of_d = of_q;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (wrap[k]) begin
        of_d[k] = 1'b1;
      end else if (of_we_i && of_wsel_i[k]) begin
        of_d[k] = of_wdata_i;
      end
    end
  end

  always_comb begin
    lcofip_d = lcofip_q;
    if (|rise) begin
      lcofip_d = 1'b1;
    end else if (lcofip_we_i) begin
      lcofip_d = lcofip_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_q     <= '0;
      lcofip_q <= 1'b0;
    end else begin
      of_q     <= of_d;
      lcofip_q <= lcofip_d;
    end
  end

  always_comb begin
    scountovf_o                    = '0;
    scountovf_o[NumCounters+2:3]   = of_q;
  end

  assign of_o     = of_q;
  assign lcofip_o = lcofip_q;
  assign irq_o    = lcofip_q & lcofie_i & ~debug_mode_i;

endmodule

// File: tb/tb_perf_overflow_irq.sv
// Bench for perf_overflow_irq: directed scenarios plus randomized traffic checked
// against a per-counter behavioural model of the overflow rules.
module tb_perf_overflow_irq;
  localparam int NC = 6;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            debug_mode_i;
  logic [NC*64-1:0] cnt_i;
  logic [NC-1:0]   cnt_inc_i, cnt_we_i, of_wsel_i;
  logic            of_we_i, of_wdata_i, lcofip_we_i, lcofip_wdata_i, lcofie_i;
  logic [NC-1:0]   of_o;
  logic [31:0]     scountovf_o;
  logic            lcofip_o, irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit of_m[NC];
  bit lcofip_m;

  perf_overflow_irq #(.NumCounters(NC)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .debug_mode_i   (debug_mode_i),
    .cnt_i          (cnt_i),
    .cnt_inc_i      (cnt_inc_i),
    .cnt_we_i       (cnt_we_i),
    .of_we_i        (of_we_i),
    .of_wsel_i      (of_wsel_i),
    .of_wdata_i     (of_wdata_i),
    .lcofip_we_i    (lcofip_we_i),
    .lcofip_wdata_i (lcofip_wdata_i),
    .lcofie_i       (lcofie_i),
    .of_o           (of_o),
    .scountovf_o    (scountovf_o),
    .lcofip_o       (lcofip_o),
    .irq_o          (irq_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [NC-1:0] model_of();
    logic [NC-1:0] v = '0;
    for (int k = 0; k < NC; k++) v[k] = of_m[k];
    return v;
  endfunction

  function automatic logic [31:0] model_scountovf();
    logic [31:0] v = 0;
    for (int k = 0; k < NC; k++) if (of_m[k]) v = v + (32'd1 << (k + 3));
    return v;
  endfunction

  task automatic set_cnt(input int k, input logic [63:0] v);
    cnt_i[k*64 +: 64] = v;
  endtask

  task automatic idle();
    cnt_inc_i = '0; cnt_we_i = '0; debug_mode_i = 0;
    of_we_i = 0; of_wsel_i = '0; of_wdata_i = 0;
    lcofip_we_i = 0; lcofip_wdata_i = 0;
  endtask

  // Evaluate the model against the inputs seen at the edge, then clock and commit.
  task automatic cycle();
    bit nof[NC];
    bit new_overflow = 0;
    bit nlc;
    for (int k = 0; k < NC; k++) begin
      nof[k] = of_m[k];
      if (cnt_inc_i[k] && cnt_i[k*64 +: 64] == 64'hFFFF_FFFF_FFFF_FFFF && !cnt_we_i[k]
          && !debug_mode_i) begin
        if (!of_m[k]) new_overflow = 1;
        nof[k] = 1;
      end else if (of_we_i && of_wsel_i[k]) begin
        nof[k] = of_wdata_i;
      end
    end
    nlc = new_overflow ? 1'b1 : (lcofip_we_i ? lcofip_wdata_i : lcofip_m);
    @(posedge clk_i);
    for (int k = 0; k < NC; k++) of_m[k] = nof[k];
    lcofip_m = nlc;
    #1;
  endtask

  task automatic reset_dut();
    #2 rst_ni = 0;
    for (int k = 0; k < NC; k++) of_m[k] = 0;
    lcofip_m = 0;
    idle();
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle(); cnt_i = '0; lcofie_i = 1;
    for (int k = 0; k < NC; k++) of_m[k] = 0;
    lcofip_m = 0;
    @(posedge clk_i); #1;
    n_checks++; if (of_o !== '0) $display("FAIL reset_of: got %h want 0", of_o); else n_pass++;
    n_checks++; if (scountovf_o !== 32'h0) $display("FAIL reset_scountovf: got %h want 0", scountovf_o); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b0) $display("FAIL reset_lcofip: got %b want 0", lcofip_o); else n_pass++;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_o); else n_pass++;
    rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_wrap();
    idle(); lcofie_i = 1;
    set_cnt(0, 64'hFFFF_FFFF_FFFF_FFFF); cnt_inc_i = 6'b000001;
    n_checks++; if (lcofip_o !== 1'b0) $display("FAIL t1_pre_lcofip: got %b want 0", lcofip_o); else n_pass++;
    cycle(); idle();
    n_checks++; if (of_o !== 6'h01) $display("FAIL t1_of: got %h want 01", of_o); else n_pass++;
    n_checks++; if (scountovf_o !== 32'h8) $display("FAIL t1_scountovf: got %h want 8", scountovf_o); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b1) $display("FAIL t1_lcofip: got %b want 1", lcofip_o); else n_pass++;
    n_checks++; if (irq_o !== 1'b1) $display("FAIL t1_irq: got %b want 1", irq_o); else n_pass++;
  endtask

  task automatic test_rewrap();
    cnt_inc_i = 6'b000001; cycle(); idle();
    n_checks++; if (of_o !== 6'h01) $display("FAIL t2_of_hold: got %h want 01", of_o); else n_pass++;
    lcofip_we_i = 1; lcofip_wdata_i = 0; cycle(); idle();
    n_checks++; if (lcofip_o !== 1'b0) $display("FAIL t2_lcofip_clr: got %b want 0", lcofip_o); else n_pass++;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL t2_irq_clr: got %b want 0", irq_o); else n_pass++;
    cnt_inc_i = 6'b000001; cycle(); idle();
    n_checks++; if (lcofip_o !== 1'b0) $display("FAIL t2_no_rearm: got %b want 0", lcofip_o); else n_pass++;
  endtask

  task automatic test_set_priority();
    set_cnt(2, 64'hFFFF_FFFF_FFFF_FFFF); cnt_inc_i = 6'b000100;
    of_we_i = 1; of_wsel_i = 6'b000100; of_wdata_i = 0;
    lcofip_we_i = 1; lcofip_wdata_i = 0;
    cycle(); idle();
    n_checks++; if (of_o[2] !== 1'b1) $display("FAIL t3_of2: got %b want 1", of_o[2]); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b1) $display("FAIL t3_lcofip: got %b want 1", lcofip_o); else n_pass++;
  endtask

  task automatic test_multi_wrap();
    reset_dut();
    set_cnt(1, 64'hFFFF_FFFF_FFFF_FFFF); set_cnt(5, 64'hFFFF_FFFF_FFFF_FFFF);
    cnt_inc_i = 6'b100010; cycle(); idle();
    n_checks++; if (scountovf_o !== 32'h110) $display("FAIL t4_scountovf: got %h want 110", scountovf_o); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b1) $display("FAIL t4_lcofip: got %b want 1", lcofip_o); else n_pass++;
    set_cnt(0, 64'hFFFF_FFFF_FFFF_FFFF); cnt_inc_i = 6'b000001; cnt_we_i = 6'b000001;
    cycle(); idle();
    n_checks++; if (of_o !== 6'b100010) $display("FAIL t4_we_mask: got %h want 22", of_o); else n_pass++;
    set_cnt(3, 64'hFFFF_FFFF_FFFF_FFFF); cnt_inc_i = 6'b001001; debug_mode_i = 1;
    #1;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL t4_irq_debug: got %b want 0", irq_o); else n_pass++;
    cycle(); idle();
    n_checks++; if (of_o !== 6'b100010) $display("FAIL t4_debug_mask: got %h want 22", of_o); else n_pass++;
    // Counter written to all-ones one cycle, incremented the next: wraps normally.
    cnt_we_i = 6'b000001; cycle(); idle();
    cnt_inc_i = 6'b000001; cycle(); idle();
    n_checks++; if (of_o !== 6'b100011) $display("FAIL t4_write_then_inc: got %h want 23", of_o); else n_pass++;
  endtask

  task automatic test_sw_of_and_reset();
    reset_dut();
    of_we_i = 1; of_wsel_i = 6'b001000; of_wdata_i = 1; cycle(); idle();
    n_checks++; if (of_o !== 6'b001000) $display("FAIL t5_sw_of: got %h want 08", of_o); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b0) $display("FAIL t5_sw_no_lcofip: got %b want 0", lcofip_o); else n_pass++;
    set_cnt(1, 64'hFFFF_FFFF_FFFF_FFFF); cnt_inc_i = 6'b000010; cycle(); idle();
    of_we_i = 1; of_wsel_i = 6'b000010; of_wdata_i = 0; cycle(); idle();
    lcofie_i = 0; #1;
    n_checks++; if (lcofip_o !== 1'b1) $display("FAIL t5_of_clr_keeps_lcofip: got %b want 1", lcofip_o); else n_pass++;
    n_checks++; if (irq_o !== 1'b0) $display("FAIL t5_irq_disabled: got %b want 0", irq_o); else n_pass++;
    lcofie_i = 1; cycle(); cycle();
    n_checks++; if (irq_o !== 1'b1) $display("FAIL t5_irq_level: got %b want 1", irq_o); else n_pass++;
    #2 rst_ni = 0; #1;
    n_checks++; if (of_o !== '0 || scountovf_o !== 32'h0)
      $display("FAIL t5_async_rst_of: got %h/%h want 0/0", of_o, scountovf_o); else n_pass++;
    n_checks++; if (lcofip_o !== 1'b0 || irq_o !== 1'b0)
      $display("FAIL t5_async_rst_irq: got %b/%b want 0/0", lcofip_o, irq_o); else n_pass++;
    for (int k = 0; k < NC; k++) of_m[k] = 0;
    lcofip_m = 0;
    @(posedge clk_i); #1; rst_ni = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NC; k++)
        set_cnt(k, ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : {$urandom, $urandom});
      cnt_inc_i      = NC'($urandom);
      cnt_we_i       = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
      debug_mode_i   = ($urandom_range(0, 9) == 0);
      of_we_i        = ($urandom_range(0, 3) == 0);
      of_wsel_i      = NC'(1 << $urandom_range(0, NC - 1));
      of_wdata_i     = $urandom_range(0, 1);
      lcofip_we_i    = ($urandom_range(0, 3) == 0);
      lcofip_wdata_i = $urandom_range(0, 1);
      lcofie_i       = $urandom_range(0, 1);
      #1;
      n_checks++;
      if (irq_o !== (lcofip_m && lcofie_i && !debug_mode_i))
        $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq_o, lcofip_m && lcofie_i && !debug_mode_i);
      else n_pass++;
      cycle();
      n_checks++;
      if (of_o !== model_of()) $display("FAIL rnd_of[%0d]: got %h want %h", i, of_o, model_of());
      else n_pass++;
      n_checks++;
      if (scountovf_o !== model_scountovf())
        $display("FAIL rnd_scountovf[%0d]: got %h want %h", i, scountovf_o, model_scountovf());
      else n_pass++;
      n_checks++;
      if (lcofip_o !== lcofip_m) $display("FAIL rnd_lcofip[%0d]: got %b want %b", i, lcofip_o, lcofip_m);
      else n_pass++;
      // Occasionally drain state so new rising edges keep appearing.
      if ($urandom_range(0, 29) == 0) reset_dut();
    end
  endtask

  initial begin
    test_reset();
    test_single_wrap();
    test_rewrap();
    test_set_priority();
    test_multi_wrap();
    test_sw_of_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
